// File: rtl/fwd_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// fwd_hazard_scoreboard
//
// Forwarding and load-use hazard unit for a pipelined CPU. It keeps a small
// shift register of the register writes in flight behind EX. Entry 1 is the
// MEM stage, entry 2 is WB, and so on up to entry DEPTH. For each EX source
// operand the unit picks the youngest matching producer as the forwarding
// source. If that producer is a load whose data is not yet available, the
// unit requests a stall instead.
//
// Ports
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset
//   freeze      : global pipeline hold (cache miss); all state holds
//   flush_ex    : squash the instruction currently in EX
//   ex_valid    : EX holds a real instruction
//   ex_regwrite : EX instruction writes a register
//   ex_memread  : EX instruction is a load
//   ex_rd       : EX destination register
//   src_addr    : operand i register at [i*REG_AW +: REG_AW]
//   src_use     : operand i is actually read
//   fwd_sel     : operand i source at [i*SEL_W +: SEL_W]; 0=regfile, k=stage k
//   stall       : load-use stall request
//   hazard_cnt  : saturating count of cycles in which a stall advanced the pipe
// ---------------------------------------------------------------------------
module fwd_hazard_scoreboard #(
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 3,
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 32,
    localparam int SEL_W   = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      freeze,
    input  logic                      flush_ex,
    input  logic                      ex_valid,
    input  logic                      ex_regwrite,
    input  logic                      ex_memread,
    input  logic [REG_AW-1:0]         ex_rd,
    input  logic [NUM_SRC*REG_AW-1:0] src_addr,
    input  logic [NUM_SRC-1:0]        src_use,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic                      stall,
    output logic [CNT_W-1:0]          hazard_cnt
);

    // In-flight entry state. Index k runs from 1 (youngest) to DEPTH (oldest).
    logic [DEPTH:1]    valid_q, valid_d;
    logic [DEPTH:1]    regwrite_q, regwrite_d;
    logic [DEPTH:1]    load_q, load_d;
    logic [REG_AW-1:0] rd_q [1:DEPTH];
    logic [REG_AW-1:0] rd_d [1:DEPTH];
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [NUM_SRC-1:0] haz;
    logic [SEL_W-1:0]   sel_arr [NUM_SRC];

    // -----------------------------------------------------------------------
    // Per-operand youngest-match search
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        logic [REG_AW-1:0] src;
        logic              hit;
        logic              ready;
        logic [SEL_W-1:0]  young;

        assign src = src_addr[gi*REG_AW +: REG_AW];

        always_comb begin
            hit   = 1'b0;
            ready = 1'b0;
            young = '0;
            // Scan from the oldest entry down to the youngest. A later hit
            // overwrites an earlier one, so the youngest match wins.
            for (int k = DEPTH; k >= 1; k--) begin
                if (valid_q[k] && regwrite_q[k] && (rd_q[k] != '0) && (rd_q[k] == src)) begin
                    hit   = 1'b1;
                    young = SEL_W'(k);
                    ready = !load_q[k] || (k >= LOAD_LAT);
                end
            end
        end

        assign haz[gi]     = src_use[gi] && hit && !ready;
        assign sel_arr[gi] = (src_use[gi] && hit && ready) ? young : '0;
        assign fwd_sel[gi*SEL_W +: SEL_W] = sel_arr[gi];
    end

    assign stall      = ex_valid && !flush_ex && (|haz);
    assign hazard_cnt = cnt_q;

    // -----------------------------------------------------------------------
    // Next state for an advancing pipeline
    // -----------------------------------------------------------------------
    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        load_d     = load_q;
        for (int k = 1; k <= DEPTH; k++) begin
            rd_d[k] = rd_q[k];
        end
        cnt_d = cnt_q;

        for (int k = DEPTH; k >= 2; k--) begin
            valid_d[k]    = valid_q[k-1];
            regwrite_d[k] = regwrite_q[k-1];
            load_d[k]     = load_q[k-1];
            rd_d[k]       = rd_q[k-1];
        end

        // A stalled instruction stays in EX and is presented again, so a
        // bubble goes into stage 1. Recording it now would count it twice.
        if (flush_ex || stall || !ex_valid) begin
            valid_d[1]    = 1'b0;
            regwrite_d[1] = 1'b0;
            load_d[1]     = 1'b0;
            rd_d[1]       = '0;
        end else begin
            valid_d[1]    = 1'b1;
            regwrite_d[1] = ex_regwrite;
            load_d[1]     = ex_memread;
            rd_d[1]       = ex_rd;
        end

        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // State registers: reset beats freeze, and freeze beats advance
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            regwrite_q <= '0;
            load_q     <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                rd_q[k] <= '0;
            end
            cnt_q <= '0;
        end else if (!freeze) begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            load_q     <= load_d;
            for (int k = 1; k <= DEPTH; k++) begin
                rd_q[k] <= rd_d[k];
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_scoreboard
//
// Testbench for the forwarding and hazard unit. A driver applies one set of
// inputs per cycle. For each cycle a reference model predicts the outputs and
// pushes them into a queue. A monitor pops that queue on the falling edge and
// compares the prediction against the DUT. The model keeps the in-flight
// instructions as a queue of records: index 0 is stage 1. Directed sequences
// cover the named scenarios, and a randomized phase follows them.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_scoreboard;

    localparam int NS = 2;
    localparam int DP = 3;
    localparam int AW = 5;
    localparam int LL = 2;
    localparam int CW = 4;
    localparam int SW = $clog2(DP + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              freeze = 1'b0;
    logic              flush_ex = 1'b0;
    logic              ex_valid = 1'b0;
    logic              ex_regwrite = 1'b0;
    logic              ex_memread = 1'b0;
    logic [AW-1:0]     ex_rd = '0;
    logic [NS*AW-1:0]  src_addr = '0;
    logic [NS-1:0]     src_use = '0;
    logic [NS*SW-1:0]  fwd_sel;
    logic              stall;
    logic [CW-1:0]     hazard_cnt;

    always #5 clk = ~clk;

    fwd_hazard_scoreboard #(
        .NUM_SRC (NS),
        .DEPTH   (DP),
        .REG_AW  (AW),
        .LOAD_LAT(LL),
        .CNT_W   (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .freeze     (freeze),
        .flush_ex   (flush_ex),
        .ex_valid   (ex_valid),
        .ex_regwrite(ex_regwrite),
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .src_addr   (src_addr),
        .src_use    (src_use),
        .fwd_sel    (fwd_sel),
        .stall      (stall),
        .hazard_cnt (hazard_cnt)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [NS*SW-1:0] fwd;
        logic             stall;
        logic [CW-1:0]    cnt;
    } exp_t;

    typedef struct {
        bit v;
        bit rw;
        bit ld;
        int rd;
    } ent_t;

    exp_t expq[$];
    ent_t pipe[$];
    int   mcnt = 0;
    bit   last_stall = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_txn = 0;

    task automatic model_reset();
        ent_t b;
        b.v = 0; b.rw = 0; b.ld = 0; b.rd = 0;
        pipe.delete();
        for (int k = 0; k < DP; k++) pipe.push_back(b);
        mcnt = 0;
    endtask

    // Drive one cycle, optionally predict its outputs, then advance the model.
    task automatic cyc(input bit r, input bit f, input bit fl, input bit v,
                       input bit rw, input bit ld, input int rd,
                       input int s0, input int s1, input bit [1:0] u,
                       input bit chk = 1'b1);
        exp_t e;
        bit   st;
        int   srcs[NS];
        ent_t n;
        @(posedge clk);
        #1;
        rst = r; freeze = f; flush_ex = fl; ex_valid = v;
        ex_regwrite = rw; ex_memread = ld; ex_rd = AW'(rd);
        src_addr = {AW'(s1), AW'(s0)};
        src_use = u;
        srcs[0] = s0; srcs[1] = s1;
        e.fwd = '0;
        st = 0;
        for (int i = 0; i < NS; i++) begin
            int y;
            y = 0;
            for (int k = 0; k < DP; k++) begin
                if (y == 0 && pipe[k].v && pipe[k].rw && pipe[k].rd != 0 && pipe[k].rd == srcs[i])
                    y = k + 1;
            end
            if (u[i] && y != 0) begin
                if (pipe[y-1].ld && y < LL) st = st | 1'b1;
                else e.fwd[i*SW +: SW] = SW'(y);
            end
        end
        st = st && v && !fl;
        e.stall = st;
        e.cnt = CW'(mcnt);
        if (chk) expq.push_back(e);
        last_stall = st;
        if (r) begin
            model_reset();
        end else if (!f) begin
            n.v = !(fl || st || !v);
            n.rw = n.v ? rw : 1'b0;
            n.ld = n.v ? ld : 1'b0;
            n.rd = n.v ? rd : 0;
            pipe.push_front(n);
            void'(pipe.pop_back());
            if (st && mcnt != (1 << CW) - 1) mcnt++;
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                n_txn++;
                $display("txn %0d: fwd_sel=%h stall=%0b hazard_cnt=%0d (exp %h %0b %0d)",
                         n_txn, fwd_sel, stall, hazard_cnt, e.fwd, e.stall, e.cnt);
                n_cmp++;
                if (fwd_sel !== e.fwd) begin
                    n_bad++;
                    $display("FAIL fwd_sel txn %0d: got %h expected %h", n_txn, fwd_sel, e.fwd);
                end
                n_cmp++;
                if (stall !== e.stall) begin
                    n_bad++;
                    $display("FAIL stall txn %0d: got %0b expected %0b", n_txn, stall, e.stall);
                end
                n_cmp++;
                if (hazard_cnt !== e.cnt) begin
                    n_bad++;
                    $display("FAIL hazard_cnt txn %0d: got %0d expected %0d", n_txn, hazard_cnt, e.cnt);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit r, f, fl, v, rw, ld;
        int rd, s0, s1;
        bit [1:0] u;

        // T1 reset; the first cycle precedes any reset edge so is not checked
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1'b0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);

        // T2 ALU chain on r3
        cyc(0, 0, 0, 1, 1, 0, 3, 0, 0, 2'b00);
        cyc(0, 0, 0, 1, 1, 0, 9, 3, 0, 2'b01);
        cyc(0, 0, 0, 1, 0, 0, 0, 3, 0, 2'b01);
        cyc(0, 0, 0, 1, 0, 0, 0, 3, 0, 2'b01);
        cyc(0, 0, 0, 1, 0, 0, 0, 3, 0, 2'b01);

        // T3 load-use on r5, operand 1
        cyc(0, 0, 0, 1, 1, 1, 5, 0, 0, 2'b00);
        cyc(0, 0, 0, 1, 1, 0, 6, 0, 5, 2'b10);
        cyc(0, 0, 0, 1, 1, 0, 6, 0, 5, 2'b10);

        // T4 priority, zero register, unused operand
        cyc(0, 0, 0, 1, 1, 0, 7, 0, 0, 2'b00);
        cyc(0, 0, 0, 1, 1, 0, 7, 0, 0, 2'b00);
        cyc(0, 0, 0, 1, 0, 0, 0, 7, 7, 2'b11);
        cyc(0, 0, 0, 1, 1, 1, 0, 0, 0, 2'b00);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b11);
        cyc(0, 0, 0, 1, 1, 1, 4, 0, 0, 2'b00);
        cyc(0, 0, 0, 1, 0, 0, 0, 4, 4, 2'b00);

        // T5 freeze with a pending load-use, then release
        cyc(0, 0, 0, 1, 1, 1, 5, 0, 0, 2'b00);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 1, 0, 0, 0, 5, 0, 2'b01);
        cyc(0, 0, 0, 1, 0, 0, 0, 5, 0, 2'b01);
        cyc(0, 0, 0, 1, 0, 0, 0, 5, 0, 2'b01);
        // same again with a reset pulse in the middle of the freeze
        cyc(0, 0, 0, 1, 1, 1, 5, 0, 0, 2'b00);
        cyc(0, 1, 0, 1, 0, 0, 0, 5, 0, 2'b01);
        cyc(1, 1, 0, 1, 0, 0, 0, 5, 0, 2'b01);
        cyc(0, 1, 0, 1, 0, 0, 0, 5, 0, 2'b01);
        cyc(0, 0, 0, 1, 0, 0, 0, 5, 0, 2'b01);

        // T6 flush of a load in EX, then counter saturation
        cyc(0, 0, 1, 1, 1, 1, 8, 0, 0, 2'b00);
        cyc(0, 0, 0, 1, 0, 0, 0, 8, 8, 2'b11);
        cyc(0, 0, 0, 1, 0, 0, 0, 8, 8, 2'b11);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 0, 1, 1, 1, 9, 0, 0, 2'b00);
            cyc(0, 0, 0, 1, 0, 0, 0, 9, 0, 2'b01);
            cyc(0, 0, 0, 1, 0, 0, 0, 9, 0, 2'b01);
        end

        // Randomized phase. A stalled instruction is re-presented unchanged.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        r = 0; f = 0; fl = 0; v = 0; rw = 0; ld = 0; rd = 0; s0 = 0; s1 = 0; u = 0;
        for (int i = 0; i < 600; i++) begin
            if (!(last_stall && !f && !r)) begin
                v  = ($urandom_range(0, 7) != 0);
                rw = ($urandom_range(0, 3) != 0);
                ld = ($urandom_range(0, 2) == 0);
                rd = $urandom_range(0, 7);
                s0 = $urandom_range(0, 7);
                s1 = $urandom_range(0, 7);
                u  = 2'($urandom_range(0, 3));
            end
            r  = ($urandom_range(0, 79) == 0);
            f  = ($urandom_range(0, 7) == 0);
            fl = ($urandom_range(0, 15) == 0);
            cyc(r, f, fl, v, rw, ld, rd, s0, s1, u);
        end

        // Let the monitor drain, within a bounded number of cycles
        for (int i = 0; i < 5 && expq.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (expq.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
